// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: registered reads (1-cycle latency),
// synchronous reset, optional hardwired-zero r0 and write-to-read bypass.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [ADDR_W-1:0] ra      [NUM_RD];
  logic [ADDR_W-1:0] wa      [NUM_WR];
  logic [DATA_W-1:0] wd      [NUM_WR];
  logic [DATA_W-1:0] rd_next [NUM_RD];

  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
      wd[j] = wr_data[j*DATA_W +: DATA_W];
    end
  end

  // Later write ports override earlier ones, matching the storage priority.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_next[i] = regs[ra[i]];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wa[j] == ra[i])) begin
            rd_next[i] = wd[j];
          end
        end
      end
      if ((ZERO_REG != 0) && (ra[i] == '0)) begin
        rd_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wa[j] == '0))) begin
          regs[wa[j]] <= wd[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed scoreboard bench for reg_file_mp across three parameter sets:
// A = dual-write/bypass/zero-reg, B = dual-write/no-bypass/no-zero-reg, C = defaults.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [63:0] rd_a, rd_b, rd_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Default parameters: only write port 0 is visible to this instance.
  reg_file_mp u_c (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_c),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0])
  );

  function automatic logic [31:0] observed(input int d, input int p);
    logic [63:0] v;
    case (d)
      0:       v = rd_a;
      1:       v = rd_b;
      default: v = rd_c;
    endcase
    return v[p*32 +: 32];
  endfunction

  task automatic expect3(input string tag, input int p,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
    sb.push_back('{tag, 0, p, ea});
    sb.push_back('{tag, 1, p, eb});
    sb.push_back('{tag, 2, p, ec});
  endtask

  task automatic set_wr(input int j, input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en[j]            = en;
    wr_addr[j*5 +: 5]   = a;
    wr_data[j*32 +: 32] = d;
  endtask

  task automatic set_rd(input int i, input logic en, input logic [4:0] a);
    rd_en[i]          = en;
    rd_addr[i*5 +: 5] = a;
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = '0;
  endtask

  // One clock: expectations queued for this cycle are checked after the edge.
  task automatic step();
    exp_t e;
    logic [31:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observed(e.dut, e.port);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s dut%0d port%0d: observed %h expected %h", e.tag, e.dut, e.port, o, e.exp);
      end
    end
  endtask

  initial begin
    // Reset: all lanes zero immediately after the reset edge
    rst = 1'b1;
    expect3("rst_init", 0, 32'h0, 32'h0, 32'h0);
    expect3("rst_init", 1, 32'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;

    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    // Reset during traffic: write and read are both ignored
    idle();
    rst = 1'b1;
    set_wr(0, 1'b1, 5'd5, 32'hCAFEF00D);
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd5);
    expect3("rst_busy", 0, 32'h0, 32'h0, 32'h0);
    expect3("rst_busy", 1, 32'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    idle();
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd5);
    expect3("rst_r5", 0, 32'h0, 32'h0, 32'h0);
    expect3("rst_r5", 1, 32'h0, 32'h0, 32'h0);
    step();

    // Basic write then read
    idle();
    set_wr(0, 1'b1, 5'd7, 32'h12345678);
    step();
    idle();
    set_rd(0, 1'b1, 5'd7);
    set_rd(1, 1'b1, 5'd0);
    expect3("basic_r7", 0, 32'h12345678, 32'h12345678, 32'h12345678);
    expect3("basic_r0", 1, 32'h0, 32'h0, 32'h0);
    step();

    // Zero register
    idle();
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    idle();
    set_rd(0, 1'b1, 5'd0);
    set_rd(1, 1'b1, 5'd0);
    expect3("zero_rd", 0, 32'h0, 32'hFFFFFFFF, 32'h0);
    expect3("zero_rd", 1, 32'h0, 32'hFFFFFFFF, 32'h0);
    step();
    set_wr(0, 1'b1, 5'd0, 32'h00000077);
    expect3("zero_byp", 0, 32'h0, 32'hFFFFFFFF, 32'h0);
    step();

    // Bypass vs pre-write read
    idle();
    set_wr(0, 1'b1, 5'd9, 32'h00000011);
    step();
    set_wr(0, 1'b1, 5'd9, 32'hA5A5A5A5);
    set_rd(0, 1'b1, 5'd9);
    set_rd(1, 1'b1, 5'd9);
    expect3("byp_same", 0, 32'hA5A5A5A5, 32'h00000011, 32'hA5A5A5A5);
    expect3("byp_same", 1, 32'hA5A5A5A5, 32'h00000011, 32'hA5A5A5A5);
    step();
    idle();
    set_rd(0, 1'b1, 5'd9);
    expect3("byp_next", 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();

    // Dual write conflict: port 1 wins (C sees only port 0)
    idle();
    set_wr(0, 1'b1, 5'd3, 32'h1);
    set_wr(1, 1'b1, 5'd3, 32'h2);
    set_rd(0, 1'b1, 5'd3);
    expect3("conf_same", 0, 32'h2, 32'h0, 32'h1);
    step();
    idle();
    set_rd(0, 1'b1, 5'd3);
    set_rd(1, 1'b1, 5'd3);
    expect3("conf_next", 0, 32'h2, 32'h2, 32'h1);
    expect3("conf_next", 1, 32'h2, 32'h2, 32'h1);
    step();

    // Read hold
    idle();
    set_wr(0, 1'b1, 5'd4, 32'h55);
    step();
    idle();
    set_rd(0, 1'b1, 5'd4);
    expect3("hold_rd", 0, 32'h55, 32'h55, 32'h55);
    expect3("hold_p1", 1, 32'h2, 32'h2, 32'h1);
    step();
    idle();
    set_rd(0, 1'b0, 5'd4);
    set_wr(0, 1'b1, 5'd4, 32'h66);
    expect3("hold_keep", 0, 32'h55, 32'h55, 32'h55);
    step();
    idle();
    expect3("hold_keep2", 0, 32'h55, 32'h55, 32'h55);
    step();
    set_rd(0, 1'b1, 5'd4);
    expect3("hold_new", 0, 32'h66, 32'h66, 32'h66);
    step();

    // Final reset clears stored contents
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rd(0, 1'b1, 5'd7);
    set_rd(1, 1'b1, 5'd4);
    expect3("rst_clr_r7", 0, 32'h0, 32'h0, 32'h0);
    expect3("rst_clr_r4", 1, 32'h0, 32'h0, 32'h0);
    step();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the single-cycle and upcoming pipelined MIPS datapaths. It is the successor to the fixed 2-read/1-write 32x32 register file. It adds:
- configurable width, depth and read/write port counts
- synchronous reset
- hardwired-zero register 0
- optional write-to-read bypass
- per-port read enables that hold registered outputs

Reads are registered, with one-cycle latency.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to read output; 0 = read returns pre-write contents

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  registered read data; port i at bits [i*DATA_W +: DATA_W]
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  write addresses, packed as rd_addr
wr_data  input  NUM_WR*DATA_W  write data, packed as rd_data

Behaviour:
- Reset: when rst=1 at a rising edge, all 2**ADDR_W registers and all rd_data lanes become 0. Writes and reads that cycle are ignored. rst has priority over every other input, including mid-burst traffic.
- Write: on a rising edge with rst=0 and wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
- Write conflict: if two write ports target the same address in the same cycle, the higher-index port wins (port 1 over port 0).
- Zero register: ZERO_REG=1 → writes to address 0 are discarded, and reads of address 0 return 0 regardless of BYPASS.
- Read: on a rising edge with rst=0 and rd_en[i]=1, rd_data[i] <= value of reg[rd_addr[i]]. Latency is exactly 1 cycle: the address is sampled at edge N and data is valid after edge N.
- Hold: rd_en[i]=0 → rd_data[i] holds its previous value, even if the underlying register is written.
- Bypass, BYPASS=1: if rd_en[i]=1 and rd_addr[i] equals the address of an enabled write in the same cycle, rd_data[i] gets the new write data. The same winning-port rule applies, and the zero-register rule overrides.
- Bypass, BYPASS=0: the same situation returns the register contents before the write.
- Multiple read ports may read the same address in the same cycle; all return identical data.
- No combinational path from any input to rd_data.
- rd_data is driven only by flops.
- Out-of-range addresses cannot occur, since depth = 2**ADDR_W.

Test Plan:
1. Reset: write 0xDEADBEEF to r5, then assert rst one cycle, then read r5 → rd_data=0. Both read lanes also read 0 immediately after the reset edge.
2. Basic write/read, default params: write r7=0x12345678; next cycle read port0=r7, port1=r0 → one cycle later port0=0x12345678, port1=0.
3. Zero register: write r0=0xFFFFFFFF, then read r0 on both ports → 0. With ZERO_REG=0, the same sequence returns 0xFFFFFFFF.
4. Bypass: same cycle write r9=0xA5A5A5A5 and read r9, with r9 previously 0x11 → BYPASS=1 gives 0xA5A5A5A5; BYPASS=0 gives 0x11, and the next read gives 0xA5A5A5A5.
5. Dual write conflict (NUM_WR=2): port0 writes r3=0x1, port1 writes r3=0x2 in the same cycle → subsequent read of r3 = 0x2. With BYPASS=1, the same-cycle read also returns 0x2.
6. Read hold: read r4=0x55 with rd_en=1, then drop rd_en and write r4=0x66 → rd_data stays 0x55. Re-asserting rd_en yields 0x66 one cycle later.
